// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode map, instruction classes, FSM state encoding and datapath
// select codes for the multicycle CPU control unit.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_LI    = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b010000;
  localparam logic [5:0] OP_JZ    = 6'b010001;
  localparam logic [5:0] OP_JNZ   = 6'b010010;
  localparam logic [5:0] OP_JS    = 6'b010011;
  localparam logic [5:0] OP_JNS   = 6'b010100;
  localparam logic [5:0] OP_CALL  = 6'b010101;
  localparam logic [5:0] OP_RET   = 6'b010110;
  localparam logic [5:0] OP_IN_R  = 6'b011000;
  localparam logic [5:0] OP_IN_I  = 6'b011001;
  localparam logic [5:0] OP_OUT_R = 6'b011010;
  localparam logic [5:0] OP_OUT_I = 6'b011011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [3:0] {
    CL_NOP, CL_ALU, CL_LI, CL_BR, CL_CALL, CL_RET, CL_IN, CL_OUT, CL_HALT
  } op_class_t;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXALU  = 4'd2,
    ST_EXLI   = 4'd3,
    ST_WB     = 4'd4,
    ST_BRANCH = 4'd5,
    ST_CALL   = 4'd6,
    ST_RET    = 4'd7,
    ST_IORD   = 4'd8,
    ST_IOWR   = 4'd9,
    ST_PCUPD  = 4'd10,
    ST_HALT   = 4'd11
  } state_t;

  localparam logic [1:0] PC_INC   = 2'd0;
  localparam logic [1:0] PC_JUMP  = 2'd1;
  localparam logic [1:0] PC_RET   = 2'd2;
  localparam logic [1:0] WD3_ALU  = 2'd0;
  localparam logic [1:0] WD3_IMM  = 2'd1;
  localparam logic [1:0] WD3_IO   = 2'd2;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: instruction class, branch-taken decision
// from the registered flags, and the ALU operation field.
module opcode_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  input  logic       s,
  output op_class_t  op_class,
  output logic       taken,
  output logic [2:0] op_alu
);

  always_comb begin
    op_class = CL_NOP;
    taken    = 1'b0;
    op_alu   = opcode[2:0];
    casez (opcode)
      6'b000???: op_class = CL_ALU;
      OP_LI:     op_class = CL_LI;
      OP_J:      begin op_class = CL_BR; taken = 1'b1; end
      OP_JZ:     begin op_class = CL_BR; taken = z;    end
      OP_JNZ:    begin op_class = CL_BR; taken = ~z;   end
      OP_JS:     begin op_class = CL_BR; taken = s;    end
      OP_JNS:    begin op_class = CL_BR; taken = ~s;   end
      OP_CALL:   op_class = CL_CALL;
      OP_RET:    op_class = CL_RET;
      OP_IN_R, OP_IN_I:   op_class = CL_IN;
      OP_OUT_R, OP_OUT_I: op_class = CL_OUT;
      OP_HALT:   op_class = CL_HALT;
      default:   op_class = CL_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle Moore sequencer for the 16-bit CPU datapath: FETCH, DECODE,
// execute, then write-back / PC update, with a wait counter for bus I/O.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int IO_WAIT      = 2,
  parameter int OPCODE_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    z,
  input  logic                    s,
  output logic [1:0]              s_pc,
  output logic [1:0]              s_wd3,
  output logic                    s_io_wr,
  output logic                    s_addr,
  output logic                    we_pc,
  output logic                    we_reg,
  output logic                    we_alu,
  output logic                    we_wd3,
  output logic                    we3,
  output logic                    we_rmem,
  output logic                    push,
  output logic                    pop,
  output logic [2:0]              op_alu,
  output logic                    read,
  output logic                    write,
  output logic                    halted,
  output logic [3:0]              state_dbg
);

  localparam logic [3:0] CNT_LAST = 4'(IO_WAIT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       w_cnt_last;
  op_class_t  w_class;
  logic       w_taken;
  logic [2:0] w_op_alu;

  opcode_decoder u_dec (
    .opcode   (opcode[5:0]),
    .z        (z),
    .s        (s),
    .op_class (w_class),
    .taken    (w_taken),
    .op_alu   (w_op_alu)
  );

  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    assert (IO_WAIT >= 1 && IO_WAIT <= 15 && OPCODE_WIDTH >= 6)
      else $error("control_unit: IO_WAIT must be 1..15 and OPCODE_WIDTH >= 6");
  end

  // The wait counter only runs in the I/O states and wraps to 0 on their last cycle.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = 4'd0;
    case (r_state)
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: begin
        case (w_class)
          CL_ALU:  w_next = ST_EXALU;
          CL_LI:   w_next = ST_EXLI;
          CL_BR:   w_next = ST_BRANCH;
          CL_CALL: w_next = ST_CALL;
          CL_RET:  w_next = ST_RET;
          CL_IN:   w_next = ST_IORD;
          CL_OUT:  w_next = ST_IOWR;
          CL_HALT: w_next = ST_HALT;
          default: w_next = ST_PCUPD;
        endcase
      end
      ST_EXALU, ST_EXLI: w_next = ST_WB;
      ST_IORD: begin
        w_next     = w_cnt_last ? ST_WB : ST_IORD;
        w_cnt_next = w_cnt_last ? 4'd0 : r_cnt + 4'd1;
      end
      ST_IOWR: begin
        w_next     = w_cnt_last ? ST_FETCH : ST_IOWR;
        w_cnt_next = w_cnt_last ? 4'd0 : r_cnt + 4'd1;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_FETCH;
    endcase
  end

  always_comb begin
    s_pc    = PC_INC;
    s_wd3   = WD3_ALU;
    s_io_wr = 1'b0;
    s_addr  = 1'b0;
    we_pc   = 1'b0;
    we_reg  = 1'b0;
    we_alu  = 1'b0;
    we_wd3  = 1'b0;
    we3     = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    op_alu  = 3'd0;
    read    = 1'b0;
    write   = 1'b0;
    halted  = 1'b0;
    case (r_state)
      ST_DECODE: we_reg = 1'b1;
      ST_EXALU: begin
        op_alu = w_op_alu;
        we_alu = 1'b1;
        we_wd3 = 1'b1;
      end
      ST_EXLI: begin
        we_wd3 = 1'b1;
        s_wd3  = WD3_IMM;
      end
      ST_WB: begin
        we3   = 1'b1;
        we_pc = 1'b1;
      end
      ST_BRANCH: begin
        we_pc = 1'b1;
        s_pc  = w_taken ? PC_JUMP : PC_INC;
      end
      ST_CALL: begin
        push  = 1'b1;
        we_pc = 1'b1;
        s_pc  = PC_JUMP;
      end
      ST_RET: begin
        pop   = 1'b1;
        we_pc = 1'b1;
        s_pc  = PC_RET;
      end
      ST_IORD: begin
        read   = 1'b1;
        s_addr = opcode[0];
        s_wd3  = WD3_IO;
        we_wd3 = 1'b1;
      end
      ST_IOWR: begin
        write   = 1'b1;
        s_addr  = 1'b1;
        s_io_wr = opcode[0];
        we_pc   = w_cnt_last;
      end
      ST_PCUPD: we_pc = 1'b1;
      ST_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign we_rmem   = 1'b0;
  assign state_dbg = r_state;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle sequencer for the 16-bit CPU datapath.
- Decodes the 6-bit opcode and the registered z/s flags.
- Drives every datapath select, write-enable, stack and I/O strobe through a Moore FSM: FETCH, DECODE, execute states, then write-back/PC update.
- Sits beside the datapath in the CPU top; the only other input is the clock/reset pair.

Parameters:
- IO_WAIT, default 2: cycles read/write stay asserted on the external bus (1..15).
- OPCODE_WIDTH, default 6: opcode field width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- opcode  in  6  datapath inst[31:26]
- z  in  1  registered zero flag
- s  in  1  registered sign flag
- s_pc  out  2  next-PC select: 0 = inc, 1 = jump, 2 = return
- s_wd3  out  2  write-data select: 0 = ALU, 1 = immediate, 2 = I/O
- s_io_wr  out  1  OUT data: 0 = register, 1 = immediate
- s_addr  out  1  bus address: 0 = register, 1 = instruction field
- we_pc, we_reg, we_alu, we_wd3, we3, we_rmem  out  1 each  write enables (we_rmem held 0, reserved)
- push, pop  out  1 each  return-stack strobes
- op_alu  out  3  ALU operation
- read, write  out  1 each  bus strobes
- halted  out  1  high in HALT state
- state_dbg  out  4  current state encoding

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: state = FETCH, wait counter = 0. All outputs 0; state_dbg = FETCH code.
- Reset during any state, including mid-I/O, returns to FETCH next edge with no further strobes.
- Outputs: Moore, decoded from state plus the opcode latched into the datapath. Everything not listed below is 0.
- FETCH: all 0 (program memory reading dir) -> DECODE.
- DECODE: we_reg=1 (latch inc_pc, jump target, immediate, rd1/rd2) -> next state by opcode class.
- Opcode map:
  - 000ooo ALU op, op_alu = ooo
  - 001000 LI
  - 010000 J; 010001 JZ; 010010 JNZ; 010011 JS; 010100 JNS
  - 010101 CALL; 010110 RET
  - 011000 IN reg-addr; 011001 IN imm-addr
  - 011010 OUT reg-data; 011011 OUT imm-data
  - 111111 HALT
  - any other opcode is a NOP: DECODE -> PCUPD.
- EXALU: op_alu=opcode[2:0], we_alu=1, we_wd3=1, s_wd3=0 -> WB.
- EXLI: we_wd3=1, s_wd3=1 -> WB.
- WB: we3=1, we_pc=1, s_pc=0 -> FETCH.
- BRANCH (one cycle): we_pc=1. s_pc=1 if taken, else 0 -> FETCH.
  - Taken conditions: J always; JZ z=1; JNZ z=0; JS s=1; JNS s=0.
  - Flags are those stored by the last EXALU; branches never write flags.
- CALL (one cycle): push=1, we_pc=1, s_pc=1 -> FETCH. The stack captures dir+1.
- RET (one cycle): pop=1, we_pc=1, s_pc=2 -> FETCH. Top of stack is valid before the pop edge.
- Stack overflow/underflow is not detected.
- IORD (IO_WAIT cycles): read=1, s_addr=opcode[0], s_wd3=2, we_wd3=1. Counter increments each cycle; at count IO_WAIT-1 -> WB, counter cleared.
- IOWR (IO_WAIT cycles): write=1, s_addr=1, s_io_wr=opcode[0]. Last cycle also we_pc=1, s_pc=0 -> FETCH.
  - read and write are never high together.
- PCUPD: we_pc=1, s_pc=0 -> FETCH.
- HALT: halted=1, all other outputs 0; stays until reset.
- Latency in cycles:
  - ALU/LI: 4
  - jumps/CALL/RET: 3
  - IN: 3+IO_WAIT
  - OUT: 2+IO_WAIT
  - NOP: 3
- IO_WAIT=1 gives a single strobe cycle. The counter is 4 bits; values out of range are a configuration error, caught by a simulation assertion.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams and class codes
  - state encoding (FETCH, DECODE, EXALU, EXLI, WB, BRANCH, CALL, RET, IORD, IOWR, PCUPD, HALT)
  - s_pc/s_wd3 select codes
- Sub-module opcode_decoder (combinational): opcode, z, s -> class, taken, op_alu.
- The FSM, wait counter and output decode stay in control_unit.

Test Plan:
- Reset held 3 cycles in IORD, then released -> all outputs 0 during reset; state_dbg = FETCH; first DECODE on cycle 2 after release.
- ADD (000010) -> we_reg in cycle 2; we_alu=we_wd3=1, op_alu=010 in cycle 3; we3=we_pc=1, s_pc=0 in cycle 4; back to FETCH.
- JZ with z=1 -> BRANCH cycle has we_pc=1, s_pc=1. Same with z=0 -> s_pc=0. JNS with s=1 -> s_pc=0.
- CALL then RET -> push=1 with s_pc=1 in CALL cycle; later pop=1 with s_pc=2, each for exactly one cycle.
- IN imm-addr with IO_WAIT=3 -> read=1, s_addr=1, s_wd3=2 for exactly 3 cycles; then WB with we3=1; total 6 cycles.
- OUT imm-data with IO_WAIT=2 -> write=1, s_io_wr=1 for 2 cycles; we_pc only on the second. Opcode 100101 -> NOP path, 3 cycles. Opcode 111111 -> halted=1 persists 20 cycles, cleared by reset.
